issue_ctrl: RTL and testbench

In-order issue controller between the instruction queue and the out-of-order back end. Each cycle it takes at most one fetched instruction and presents the raw word to the combinational decoder. It then allocates a reorder-buffer tag and dispatches the decoded fields, one cycle later, to either the reservation station or the load/store buffer. It owns ROB tag allocation and occupancy, stalls on back-end back-pressure, and discards in-flight state on a pipeline flush.

---
 rtl/issue_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_issue_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// In-order issue controller: allocates ROB tags and dispatches decoded fields to RS or LSB.
// Optional: define ISSUE_STALL_CNT_EN to add the stall_cnt output and its counter.
module issue_ctrl #(
  parameter int ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 iq_valid,
  input  logic [31:0]          iq_inst,
  input  logic [31:0]          iq_pc,
  input  logic                 iq_pred,
  output logic                 iq_ready,
  output logic [31:0]          dec_inst,
  input  logic [2:0]           dec_type,
  input  logic [5:0]           dec_name,
  input  logic [4:0]           dec_rd,
  input  logic [4:0]           dec_rs1,
  input  logic [4:0]           dec_rs2,
  input  logic [31:0]          dec_imm,
  input  logic                 dec_is_imm,
  input  logic                 dec_is_pc,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  input  logic                 commit_valid,
  input  logic                 flush_in,
  output logic                 iss_valid,
  output logic                 iss_to_lsb,
  output logic [ROB_WIDTH-1:0] iss_tag,
  output logic [5:0]           iss_name,
  output logic [4:0]           iss_rd,
  output logic [4:0]           iss_rs1,
  output logic [4:0]           iss_rs2,
  output logic [31:0]          iss_imm,
  output logic                 iss_is_imm,
  output logic                 iss_is_pc,
  output logic [31:0]          iss_pc,
  output logic                 iss_pred,
  output logic [ROB_WIDTH:0]   rob_count
`ifdef ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  localparam logic [2:0]         TYPE_MEM  = 3'd1;
  localparam logic [5:0]         NAME_LW   = 6'd10;
  localparam logic [ROB_WIDTH:0] ROB_DEPTH = {1'b1, {ROB_WIDTH{1'b0}}};
  localparam logic [ROB_WIDTH:0] CNT_ONE   = {{ROB_WIDTH{1'b0}}, 1'b1};
  localparam logic [ROB_WIDTH-1:0] TAG_ONE = {{(ROB_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic                 to_lsb;
    logic [ROB_WIDTH-1:0] tag;
    logic [5:0]           name;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [31:0]          imm;
    logic                 is_imm;
    logic                 is_pc;
    logic [31:0]          pc;
    logic                 pred;
  } iss_t;

  state_e               state_q, state_d;
  logic [ROB_WIDTH-1:0] tail_q, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;
  logic                 valid_q, valid_d;
  iss_t                 iss_q, iss_d;

  logic to_lsb_s;
  logic tgt_full_s;
  logic issue_s;
  logic commit_s;

  // Issue qualification; target is chosen from the decoder's view of the current queue head.
  always_comb begin
    to_lsb_s   = (dec_name == NAME_LW) || (dec_type == TYPE_MEM);
    tgt_full_s = to_lsb_s ? lsb_full : rs_full;
    issue_s    = rdy_in && iq_valid && (state_q == ST_RUN) && (count_q != ROB_DEPTH)
                 && !tgt_full_s && !flush_in;
    commit_s   = commit_valid && (count_q != {(ROB_WIDTH+1){1'b0}});
  end

  assign iq_ready = issue_s;
  assign dec_inst = iq_inst;

  // Next-state logic: flush wins over issue and commit; rdy_in low freezes everything.
  always_comb begin
    state_d = state_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    iss_d   = iss_q;
    if (rdy_in) begin
      if (flush_in) begin
        state_d = ST_FLUSH;
        tail_d  = {ROB_WIDTH{1'b0}};
        count_d = {(ROB_WIDTH+1){1'b0}};
        valid_d = 1'b0;
      end else begin
        case (state_q)
          ST_RUN:   state_d = ST_RUN;
          ST_FLUSH: state_d = ST_RUN;
          default:  state_d = ST_RUN;
        endcase
        valid_d = issue_s;
        if (issue_s) begin
          iss_d.to_lsb = to_lsb_s;
          iss_d.tag    = tail_q;
          iss_d.name   = dec_name;
          iss_d.rd     = dec_rd;
          iss_d.rs1    = dec_rs1;
          iss_d.rs2    = dec_rs2;
          iss_d.imm    = dec_imm;
          iss_d.is_imm = dec_is_imm;
          iss_d.is_pc  = dec_is_pc;
          iss_d.pc     = iq_pc;
          iss_d.pred   = iq_pred;
          tail_d       = tail_q + TAG_ONE;
        end else begin
          iss_d  = iss_q;
          tail_d = tail_q;
        end
        case ({issue_s, commit_s})
          2'b10:   count_d = count_q + CNT_ONE;
          2'b01:   count_d = count_q - CNT_ONE;
          default: count_d = count_q;
        endcase
      end
    end else begin
      state_d = state_q;
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_RUN;
      tail_q  <= {ROB_WIDTH{1'b0}};
      count_q <= {(ROB_WIDTH+1){1'b0}};
      valid_q <= 1'b0;
      iss_q   <= '0;
    end else begin
      state_q <= state_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      iss_q   <= iss_d;
    end
  end

  assign iss_valid  = valid_q;
  assign iss_to_lsb = iss_q.to_lsb;
  assign iss_tag    = iss_q.tag;
  assign iss_name   = iss_q.name;
  assign iss_rd     = iss_q.rd;
  assign iss_rs1    = iss_q.rs1;
  assign iss_rs2    = iss_q.rs2;
  assign iss_imm    = iss_q.imm;
  assign iss_is_imm = iss_q.is_imm;
  assign iss_is_pc  = iss_q.is_pc;
  assign iss_pc     = iss_q.pc;
  assign iss_pred   = iss_q.pred;
  assign rob_count  = count_q;

`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_q;

  // Counts enabled cycles where the queue offers an instruction that is not taken; flush does not clear it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_q <= 32'd0;
    end else if (rdy_in && iq_valid && !issue_s) begin
      stall_q <= stall_q + 32'd1;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: a cycle model of the ROB/issue rules checked every negedge,
// plus literal expectations from the hand-worked scenarios.
module tb_issue_ctrl;

  localparam int RW    = 3;
  localparam int DEPTH = 8;
  localparam logic [2:0] TYPE_REG = 3'd0;
  localparam logic [2:0] TYPE_MEM = 3'd1;
  localparam logic [2:0] TYPE_BR  = 3'd2;
  localparam logic [5:0] NAME_ADD = 6'd1;
  localparam logic [5:0] NAME_BEQ = 6'd20;
  localparam logic [5:0] NAME_LW  = 6'd10;
  localparam logic [5:0] NAME_SW  = 6'd15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in, rdy_in, iq_valid, iq_pred, iq_ready;
  logic [31:0] iq_inst, iq_pc, dec_inst, dec_imm;
  logic [2:0] dec_type;
  logic [5:0] dec_name;
  logic [4:0] dec_rd, dec_rs1, dec_rs2;
  logic dec_is_imm, dec_is_pc, rs_full, lsb_full, commit_valid, flush_in;
  logic iss_valid, iss_to_lsb, iss_is_imm, iss_is_pc, iss_pred;
  logic [RW-1:0] iss_tag;
  logic [5:0] iss_name;
  logic [4:0] iss_rd, iss_rs1, iss_rs2;
  logic [31:0] iss_imm, iss_pc;
  logic [RW:0] rob_count;
`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  issue_ctrl #(.ROB_WIDTH(RW)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_pred(iq_pred),
    .iq_ready(iq_ready), .dec_inst(dec_inst),
    .dec_type(dec_type), .dec_name(dec_name), .dec_rd(dec_rd), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_imm(dec_imm), .dec_is_imm(dec_is_imm), .dec_is_pc(dec_is_pc),
    .rs_full(rs_full), .lsb_full(lsb_full), .commit_valid(commit_valid), .flush_in(flush_in),
    .iss_valid(iss_valid), .iss_to_lsb(iss_to_lsb), .iss_tag(iss_tag), .iss_name(iss_name),
    .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_imm(iss_imm),
    .iss_is_imm(iss_is_imm), .iss_is_pc(iss_is_pc), .iss_pc(iss_pc), .iss_pred(iss_pred),
    .rob_count(rob_count)
`ifdef ISSUE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: ROB occupancy and tail as plain integers, the flush bubble as a flag.
  int m_count, m_tail, m_tag;
  bit m_flush_bubble, m_valid, m_lsb, m_is_imm, m_is_pc, m_pred;
  logic [5:0] m_name;
  logic [4:0] m_rd, m_rs1, m_rs2;
  logic [31:0] m_imm, m_pc, m_stall;

  function automatic bit goes_to_lsb();
    return (dec_name == NAME_LW) || (dec_type == TYPE_MEM);
  endfunction

  function automatic bit model_ready();
    if (!rdy_in || !iq_valid || flush_in || m_flush_bubble) return 1'b0;
    if (m_count >= DEPTH) return 1'b0;
    if (goes_to_lsb() ? lsb_full : rs_full) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit take;
    take = model_ready();
    if (rst_in) begin
      m_count = 0; m_tail = 0; m_tag = 0; m_flush_bubble = 0; m_valid = 0; m_lsb = 0;
      m_name = 6'd0; m_rd = 5'd0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_imm = 32'd0;
      m_is_imm = 0; m_is_pc = 0; m_pc = 32'd0; m_pred = 0; m_stall = 32'd0;
    end else if (rdy_in) begin
      if (iq_valid && !take) m_stall = m_stall + 32'd1;
      if (flush_in) begin
        m_count = 0; m_tail = 0; m_valid = 0; m_flush_bubble = 1;
      end else begin
        m_flush_bubble = 0;
        m_valid = take;
        if (commit_valid && m_count > 0) m_count = m_count - 1;
        if (take) begin
          m_lsb = goes_to_lsb(); m_tag = m_tail; m_tail = (m_tail + 1) % DEPTH;
          m_count = m_count + 1;
          m_name = dec_name; m_rd = dec_rd; m_rs1 = dec_rs1; m_rs2 = dec_rs2;
          m_imm = dec_imm; m_is_imm = dec_is_imm; m_is_pc = dec_is_pc;
          m_pc = iq_pc; m_pred = iq_pred;
        end
      end
    end
  end

  // Compare process: all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("iq_ready", 64'(iq_ready), 64'(model_ready()));
      chk("dec_inst", 64'(dec_inst), 64'(iq_inst));
      chk("iss_valid", 64'(iss_valid), 64'(m_valid));
      chk("rob_count", 64'(rob_count), 64'(m_count));
      chk("iss_tag", 64'(iss_tag), 64'(m_tag));
      chk("iss_to_lsb", 64'(iss_to_lsb), 64'(m_lsb));
      chk("iss_name", 64'(iss_name), 64'(m_name));
      chk("iss_regs", 64'({iss_rd, iss_rs1, iss_rs2}), 64'({m_rd, m_rs1, m_rs2}));
      chk("iss_imm", 64'(iss_imm), 64'(m_imm));
      chk("iss_flags", 64'({iss_is_imm, iss_is_pc, iss_pred}), 64'({m_is_imm, m_is_pc, m_pred}));
      chk("iss_pc", 64'(iss_pc), 64'(m_pc));
`ifdef ISSUE_STALL_CNT_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_inst(input logic [31:0] inst, input logic [2:0] ty, input logic [5:0] nm,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm, input logic ii);
    iq_inst = inst; dec_type = ty; dec_name = nm; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
    dec_imm = imm; dec_is_imm = ii; dec_is_pc = (ty == TYPE_BR);
    iq_pc = pc_ctr; iq_pred = pc_ctr[2]; pc_ctr = pc_ctr + 32'd4;
  endtask

  task automatic set_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    set_inst({7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011}, TYPE_REG, NAME_ADD, rd, rs1, rs2, 32'd0, 1'b0);
  endtask

  task automatic set_lw();
    set_inst(32'h0081_2283, TYPE_MEM, NAME_LW, 5'd5, 5'd2, 5'd0, 32'd8, 1'b1);
  endtask

  task automatic set_sw();
    set_inst(32'h0051_2223, TYPE_MEM, NAME_SW, 5'd0, 5'd2, 5'd5, 32'd4, 1'b1);
  endtask

  task automatic do_reset();
    rst_in = 1'b1; iq_valid = 1'b0; commit_valid = 1'b0; flush_in = 1'b0;
    rs_full = 1'b0; lsb_full = 1'b0; rdy_in = 1'b1;
    cyc();
    rst_in = 1'b0;
  endtask

  initial begin
    logic [31:0] stall_snap;
    stall_snap = 32'd0;
    rst_in = 1'b1; rdy_in = 1'b1; iq_valid = 1'b0; commit_valid = 1'b0; flush_in = 1'b0;
    rs_full = 1'b0; lsb_full = 1'b0;
    set_add(5'd0, 5'd0, 5'd0);
    cyc(); cyc();
    rst_in = 1'b0;
    chk_en = 1'b1;
    chk("reset_iss_valid", 64'(iss_valid), 64'd0);
    chk("reset_rob_count", 64'(rob_count), 64'd0);
    chk("reset_iss_tag", 64'(iss_tag), 64'd0);

    // add x1,x2,x3
    set_add(5'd1, 5'd2, 5'd3); iq_valid = 1'b1;
    #1 chk("add_inst_word", 64'(iq_inst), 64'h0031_00B3);
    chk("add_ready", 64'(iq_ready), 64'd1);
    cyc(); iq_valid = 1'b0;
    chk("add_valid", 64'(iss_valid), 64'd1);
    chk("add_to_lsb", 64'(iss_to_lsb), 64'd0);
    chk("add_tag", 64'(iss_tag), 64'd0);
    chk("add_rd", 64'(iss_rd), 64'd1);
    chk("add_count", 64'(rob_count), 64'd1);
    cyc();
    chk("add_strobe_one_cycle", 64'(iss_valid), 64'd0);
    commit_valid = 1'b1; cyc();
    chk("commit_dec", 64'(rob_count), 64'd0);
    cyc(); commit_valid = 1'b0;
    chk("commit_at_zero_ignored", 64'(rob_count), 64'd0);

    // lw then sw back-to-back
    do_reset();
    set_lw(); iq_valid = 1'b1; cyc();
    chk("lw_lsb", 64'(iss_to_lsb), 64'd1);
    chk("lw_tag", 64'(iss_tag), 64'd0);
    chk("lw_imm", 64'(iss_imm), 64'd8);
    set_sw(); cyc(); iq_valid = 1'b0;
    chk("sw_lsb", 64'(iss_to_lsb), 64'd1);
    chk("sw_tag", 64'(iss_tag), 64'd1);
    chk("sw_imm", 64'(iss_imm), 64'd4);
    chk("lwsw_count", 64'(rob_count), 64'd2);

    // Fill the ROB, hold the 9th, commit while full, then wrap to tag 0
    do_reset();
    iq_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_add(5'(i + 1), 5'd2, 5'd3); cyc();
    end
    chk("full_count", 64'(rob_count), 64'd8);
    chk("full_last_tag", 64'(iss_tag), 64'd7);
    set_add(5'd9, 5'd2, 5'd3);
    #1 chk("full_held", 64'(iq_ready), 64'd0);
    cyc();
    chk("full_no_issue", 64'(iss_valid), 64'd0);
    commit_valid = 1'b1;
    #1 chk("full_commit_held", 64'(iq_ready), 64'd0);
    cyc(); commit_valid = 1'b0;
    chk("full_after_commit", 64'(rob_count), 64'd7);
    #1 chk("full_resume_ready", 64'(iq_ready), 64'd1);
    cyc(); iq_valid = 1'b0;
    chk("wrap_tag", 64'(iss_tag), 64'd0);
    chk("wrap_rd", 64'(iss_rd), 64'd9);
    chk("wrap_count", 64'(rob_count), 64'd8);

    // LSB back-pressure blocks lw and everything behind it
    do_reset();
    set_lw(); lsb_full = 1'b1; iq_valid = 1'b1;
    #1 chk("lsb_full_held", 64'(iq_ready), 64'd0);
    cyc(); cyc();
    chk("lsb_full_no_issue", 64'(iss_valid), 64'd0);
    lsb_full = 1'b0;
    #1 chk("lsb_free_ready", 64'(iq_ready), 64'd1);
    cyc();
    chk("lsb_lw_tag", 64'(iss_tag), 64'd0);
    set_add(5'd7, 5'd1, 5'd2); cyc();
    chk("inorder_add_tag", 64'(iss_tag), 64'd1);
    chk("inorder_add_rs", 64'(iss_to_lsb), 64'd0);
    set_inst(32'h0020_8463, TYPE_BR, NAME_BEQ, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    rs_full = 1'b1; lsb_full = 1'b1;
    #1 chk("rs_full_held", 64'(iq_ready), 64'd0);
    cyc(); rs_full = 1'b0;
    cyc(); iq_valid = 1'b0; lsb_full = 1'b0;
    chk("br_to_rs", 64'(iss_to_lsb), 64'd0);
    chk("br_tag", 64'(iss_tag), 64'd2);

    // Flush at rob_count=5
    do_reset();
    iq_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_add(5'(i + 10), 5'd1, 5'd1); cyc();
    end
    chk("pre_flush_count", 64'(rob_count), 64'd5);
    flush_in = 1'b1;
    #1 chk("flush_no_issue", 64'(iq_ready), 64'd0);
    cyc(); flush_in = 1'b0;
    chk("flush_count", 64'(rob_count), 64'd0);
    chk("flush_valid", 64'(iss_valid), 64'd0);
    #1 chk("flush_bubble", 64'(iq_ready), 64'd0);
    cyc();
    #1 chk("post_flush_ready", 64'(iq_ready), 64'd1);
    cyc();
    chk("post_flush_tag", 64'(iss_tag), 64'd0);
    chk("post_flush_valid", 64'(iss_valid), 64'd1);

    // rdy_in low freezes state, including a held iss_valid
`ifdef ISSUE_STALL_CNT_EN
    stall_snap = stall_cnt;
`endif
    rdy_in = 1'b0; commit_valid = 1'b1; set_add(5'd20, 5'd1, 5'd1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("frozen_ready", 64'(iq_ready), 64'd0);
      cyc();
    end
    chk("frozen_valid", 64'(iss_valid), 64'd1);
    chk("frozen_count", 64'(rob_count), 64'd1);
    chk("frozen_tag", 64'(iss_tag), 64'd0);
`ifdef ISSUE_STALL_CNT_EN
    chk("frozen_stall", 64'(stall_cnt), 64'(stall_snap));
`endif
    rdy_in = 1'b1; commit_valid = 1'b0; cyc();
    chk("unfrozen_tag", 64'(iss_tag), 64'd1);
    chk("unfrozen_count", 64'(rob_count), 64'd2);

    // Reset wins even with rdy_in low
    rst_in = 1'b1; rdy_in = 1'b0; cyc();
    rst_in = 1'b0; rdy_in = 1'b1; iq_valid = 1'b0;
    chk("rst_norun_count", 64'(rob_count), 64'd0);
    chk("rst_norun_valid", 64'(iss_valid), 64'd0);
    chk("rst_norun_rd", 64'(iss_rd), 64'd0);
    cyc(); cyc();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
